spi_load_sequencer: RTL and testbench

Wishbone master that runs a short list of flash-to-memory load jobs through the SPI loader peripheral without CPU involvement. Each job is a descriptor: flash address, target memory select, and byte count. For each job the block programs the loader registers, starts the transfer, and polls the valid flag until the transfer completes. It sits between the boot/host control logic and the SPI loader's Wishbone slave port.

---
 rtl/spi_load_sequencer.sv | 175 +++++++++++++++++
 tb/tb_spi_load_sequencer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/spi_load_sequencer.sv
// Wishbone master that walks a descriptor table, programming the SPI loader and polling its
// valid flag per job. Optional poll watchdog enabled by SPI_LOAD_SEQ_TIMEOUT_EN.
module spi_load_sequencer #(
  parameter int          N_DESC    = 4,
  parameter logic [31:0] SPI_BASE  = 32'h0000_0000,
  parameter logic [3:0]  SEL_ADDR  = 4'd0,
  parameter logic [3:0]  SEL_MEM   = 4'd1,
  parameter logic [3:0]  SEL_SIZE  = 4'd2,
  parameter logic [3:0]  SEL_START = 4'd3,
  parameter logic [3:0]  SEL_VALID = 4'd4,
  parameter int          POLL_GAP  = 8,
  parameter logic [23:0] TIMEOUT   = 24'hFF_FFFF
) (
  input  logic                      i_wb_clk,
  input  logic                      i_wb_rst_n,
  input  logic                      i_cfg_we,
  input  logic [$clog2(N_DESC)-1:0] i_cfg_idx,
  input  logic [1:0]                i_cfg_field,
  input  logic [31:0]               i_cfg_dat,
  input  logic [$clog2(N_DESC):0]   i_num_jobs,
  input  logic                      i_go,
  input  logic                      i_abort,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_err,
  output logic [$clog2(N_DESC)-1:0] o_job_idx,
  output logic [31:0]               o_wb_adr,
  output logic [31:0]               o_wb_dat,
  output logic                      o_wb_we,
  output logic                      o_wb_cyc,
  input  logic [31:0]               i_wb_rdt,
  input  logic                      i_wb_ack
);
  localparam int IW = $clog2(N_DESC);
  localparam int GW = $clog2(POLL_GAP + 1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_WR_ADR, S_WR_MEM, S_WR_SIZE, S_WR_START, S_POLL, S_NEXT, S_DONE
  } state_e;

  state_e                     state_q, state_d, wr_nxt;
  logic [N_DESC-1:0][23:0]    daddr_q;
  logic [N_DESC-1:0][1:0]     dmem_q;
  logic [N_DESC-1:0][17:0]    dsize_q;
  logic [23:0]                cur_addr_q, cur_addr_d;
  logic [1:0]                 cur_mem_q, cur_mem_d;
  logic [17:0]                cur_size_q, cur_size_d;
  logic [IW:0]                job_q, job_d, num_q, num_d;
  logic [GW-1:0]              gap_q, gap_d;
  logic                       cyc_q, cyc_d, we_q, we_d;
  logic [31:0]                adr_q, adr_d, dat_q, dat_d, wr_dat;
  logic [3:0]                 wr_sel;
  logic                       abort_q, abort_d, err_q, err_d, zdone_q, zdone_d;
  logic                       busy, stop, to_hit;

  function automatic logic [31:0] reg_adr(input logic [3:0] sel);
    return SPI_BASE | {12'h0, sel, 16'h0};
  endfunction

`ifdef SPI_LOAD_SEQ_TIMEOUT_EN
  logic [23:0] to_q, to_d;
  logic        unused_ok;
  assign unused_ok = ^{i_wb_rdt[31:1], i_cfg_dat[31:24]};
  assign to_hit    = (state_q == S_POLL) && (to_q == TIMEOUT);
  // Held at zero outside POLL, so every POLL entry starts a fresh count.
  always_comb begin
    to_d = to_q;
    if (state_q != S_POLL)  to_d = '0;
    else if (to_q != TIMEOUT) to_d = to_q + 24'd1;
  end
  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n)
    if (!i_wb_rst_n) to_q <= '0;
    else             to_q <= to_d;
`else
  logic unused_ok;
  assign unused_ok = ^{i_wb_rdt[31:1], i_cfg_dat[31:24], TIMEOUT};
  assign to_hit    = 1'b0;
`endif

  assign busy = (state_q != S_IDLE);
  assign stop = abort_q | i_abort | to_hit;

  always_comb begin
    wr_sel = SEL_ADDR; wr_dat = {8'h0, cur_addr_q}; wr_nxt = S_WR_MEM;
    case (state_q)
      S_WR_MEM:   begin wr_sel = SEL_MEM;   wr_dat = {30'h0, cur_mem_q};  wr_nxt = S_WR_SIZE;  end
      S_WR_SIZE:  begin wr_sel = SEL_SIZE;  wr_dat = {14'h0, cur_size_q}; wr_nxt = S_WR_START; end
      S_WR_START: begin wr_sel = SEL_START; wr_dat = 32'd1;               wr_nxt = S_POLL;     end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q; cyc_d = cyc_q; adr_d = adr_q; dat_d = dat_q; we_d = we_q;
    job_d = job_q; num_d = num_q; gap_d = gap_q; err_d = err_q; zdone_d = 1'b0;
    cur_addr_d = cur_addr_q; cur_mem_d = cur_mem_q; cur_size_d = cur_size_q;
    abort_d = abort_q | (busy & i_abort);
    if (cyc_q && i_wb_ack) cyc_d = 1'b0;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        if (i_go) begin
          err_d = 1'b0;
          if (i_num_jobs != '0) begin
            num_d = i_num_jobs; job_d = '0; state_d = S_LOAD;
          end else zdone_d = 1'b1;
        end
      end
      S_LOAD: begin
        // Snapshot so cfg writes to the running slot only land on its next LOAD.
        cur_addr_d = daddr_q[job_q[IW-1:0]];
        cur_mem_d  = dmem_q[job_q[IW-1:0]];
        cur_size_d = dsize_q[job_q[IW-1:0]];
        state_d    = S_WR_ADR;
      end
      S_WR_ADR, S_WR_MEM, S_WR_SIZE, S_WR_START: begin
        if (!cyc_q) begin
          if (!stop) begin cyc_d = 1'b1; we_d = 1'b1; adr_d = reg_adr(wr_sel); dat_d = wr_dat; end
        end else if (i_wb_ack) state_d = wr_nxt;
      end
      S_POLL: begin
        if (!cyc_q) begin
          if (!stop) begin
            if (gap_q == GW'(POLL_GAP - 1)) begin
              cyc_d = 1'b1; we_d = 1'b0; adr_d = reg_adr(SEL_VALID); dat_d = '0; gap_d = '0;
            end else gap_d = gap_q + 1'b1;
          end
        end else if (i_wb_ack && i_wb_rdt[0]) state_d = S_NEXT;
      end
      S_NEXT: begin
        job_d   = job_q + 1'b1;
        state_d = ((job_q + 1'b1) == num_q) ? S_DONE : S_LOAD;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Abort/timeout only takes effect once no bus cycle is left open.
    if (busy && (state_q != S_DONE) && stop && (!cyc_q || i_wb_ack)) begin
      state_d = S_IDLE; cyc_d = 1'b0; err_d = 1'b1; abort_d = 1'b0; gap_d = '0;
    end
  end

  always_ff @(posedge i_wb_clk or negedge i_wb_rst_n) begin
    if (!i_wb_rst_n) begin
      state_q <= S_IDLE; daddr_q <= '0; dmem_q <= '0; dsize_q <= '0;
      cur_addr_q <= '0; cur_mem_q <= '0; cur_size_q <= '0;
      job_q <= '0; num_q <= '0; gap_q <= '0;
      cyc_q <= 1'b0; we_q <= 1'b0; adr_q <= '0; dat_q <= '0;
      abort_q <= 1'b0; err_q <= 1'b0; zdone_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_addr_q <= cur_addr_d; cur_mem_q <= cur_mem_d; cur_size_q <= cur_size_d;
      job_q <= job_d; num_q <= num_d; gap_q <= gap_d;
      cyc_q <= cyc_d; we_q <= we_d; adr_q <= adr_d; dat_q <= dat_d;
      abort_q <= abort_d; err_q <= err_d; zdone_q <= zdone_d;
      if (i_cfg_we) begin
        case (i_cfg_field)
          2'd0:    daddr_q[i_cfg_idx] <= i_cfg_dat[23:0];
          2'd1:    dmem_q[i_cfg_idx]  <= i_cfg_dat[1:0];
          2'd2:    dsize_q[i_cfg_idx] <= i_cfg_dat[17:0];
          default: ;
        endcase
      end
    end
  end

  assign o_busy    = busy;
  assign o_done    = (state_q == S_DONE) | zdone_q;
  assign o_err     = err_q;
  assign o_job_idx = job_q[IW-1:0];
  assign o_wb_adr  = adr_q;
  assign o_wb_dat  = dat_q;
  assign o_wb_we   = we_q;
  assign o_wb_cyc  = cyc_q;
endmodule

// File: tb/tb_spi_load_sequencer.sv
// Randomized bench for spi_load_sequencer: transaction-level model of the expected bus traffic
// per job list, a responding slave, and one monitor checking protocol and traffic every cycle.
`timescale 1ns/1ps
module tb_spi_load_sequencer;
  localparam int          N_DESC   = 4;
  localparam int          IW       = 2;
  localparam int          POLL_GAP = 8;
  localparam logic [31:0] BASE     = 32'h4000_0000;

  logic clk = 1'b0, rst_n = 1'b0;
  logic cfg_we = 1'b0; logic [IW-1:0] cfg_idx = '0; logic [1:0] cfg_field = '0;
  logic [31:0] cfg_dat = '0; logic [IW:0] num_jobs = '0; logic go = 1'b0, abort = 1'b0;
  logic busy, done, err; logic [IW-1:0] job_idx;
  logic [31:0] wb_adr, wb_dat; logic [31:0] wb_rdt = '0; logic wb_we, wb_cyc; logic wb_ack = 1'b0;

  spi_load_sequencer #(.N_DESC(N_DESC), .SPI_BASE(BASE), .POLL_GAP(POLL_GAP)) dut (
    .i_wb_clk(clk), .i_wb_rst_n(rst_n), .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx),
    .i_cfg_field(cfg_field), .i_cfg_dat(cfg_dat), .i_num_jobs(num_jobs), .i_go(go),
    .i_abort(abort), .o_busy(busy), .o_done(done), .o_err(err), .o_job_idx(job_idx),
    .o_wb_adr(wb_adr), .o_wb_dat(wb_dat), .o_wb_we(wb_we), .o_wb_cyc(wb_cyc),
    .i_wb_rdt(wb_rdt), .i_wb_ack(wb_ack));

  always #5 clk = ~clk;

  typedef struct { logic [31:0] adr; logic [31:0] dat; logic we; logic [IW-1:0] job; } tr_t;
  tr_t exp_q[$];
  tr_t m_e;
  int total = 0, bad = 0, done_cnt = 0, tr_cnt = 0, wr_cnt = 0;
  logic [23:0] m_addr [N_DESC];
  logic [1:0]  m_mem  [N_DESC];
  logic [17:0] m_size [N_DESC];
  int polls [N_DESC];
  int ack_dly_fixed = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin bad++; $display("FAIL %s act=%h exp=%h", nm, act, exp); end
  endtask

  // Slave: acks after a delay; valid bit returned on the polls[job]-th read of each job.
  int s_job = 0, s_rc = 0, s_wait = 0, s_dly = 0; logic s_act = 1'b0; logic [31:0] s_r;
  always @(negedge clk) begin
    if (!rst_n) begin wb_ack = 1'b0; s_act = 1'b0; end
    else if (wb_ack) wb_ack = 1'b0;
    else if (wb_cyc) begin
      if (!s_act) begin
        s_act = 1'b1; s_wait = 0;
        s_dly = (ack_dly_fixed >= 0) ? ack_dly_fixed : int'($urandom_range(0, 3));
      end
      if (s_wait >= s_dly) begin
        s_r = $urandom;
        if (!wb_we) begin
          if (s_rc + 1 >= ((s_job < N_DESC) ? polls[s_job] : 1)) begin
            s_r[0] = 1'b1; s_rc = 0; s_job++;
          end else begin s_r[0] = 1'b0; s_rc++; end
        end
        wb_rdt = s_r; wb_ack = 1'b1; s_act = 1'b0;
      end else s_wait++;
    end
  end

  // Monitor: protocol rules and traffic vs expected queue, sampled just after each edge.
  logic p_cyc = 1'b0, p_we = 1'b0; logic [31:0] p_adr = '0, p_dat = '0; logic [IW-1:0] p_job = '0;
  int idle = 0;
  always @(posedge clk) begin
    #1;
    if (!rst_n) begin p_cyc = 1'b0; idle = 0; end
    else begin
      if (done) begin done_cnt++; chk("done_all_traffic", exp_q.size(), 0); end
      if (wb_cyc) chk("busy_in_cyc", {31'h0, busy}, 32'h1);
      if (p_cyc) begin
        if (wb_ack) begin
          chk("cyc_drop_after_ack", {31'h0, wb_cyc}, 32'h0);
          tr_cnt++; if (p_we) wr_cnt++;
          if (exp_q.size() == 0) begin
            total++; bad++; $display("FAIL unexpected_tr adr=%h dat=%h we=%0b", p_adr, p_dat, p_we);
          end else begin
            m_e = exp_q.pop_front();
            chk("tr_adr", p_adr, m_e.adr);
            chk("tr_we", {31'h0, p_we}, {31'h0, m_e.we});
            chk("tr_job", {30'h0, p_job}, {30'h0, m_e.job});
            if (m_e.we) chk("tr_dat", p_dat, m_e.dat);
          end
        end else begin
          chk("cyc_hold", {31'h0, wb_cyc}, 32'h1);
          chk("adr_stable", wb_adr, p_adr);
          chk("dat_stable", wb_dat, p_dat);
          chk("we_stable", {31'h0, wb_we}, {31'h0, p_we});
        end
      end
      if (wb_cyc && !p_cyc && !wb_we) chk("poll_gap", idle, POLL_GAP);
      idle = wb_cyc ? 0 : idle + 1;
      p_cyc = wb_cyc; p_we = wb_we; p_adr = wb_adr; p_dat = wb_dat; p_job = job_idx;
    end
  end

  task automatic cfg(int idx, int field, logic [31:0] d);
    @(negedge clk); cfg_we = 1'b1; cfg_idx = idx[IW-1:0]; cfg_field = field[1:0]; cfg_dat = d;
    @(negedge clk); cfg_we = 1'b0;
    case (field)
      0: m_addr[idx] = d[23:0];
      1: m_mem[idx]  = d[1:0];
      2: m_size[idx] = d[17:0];
      default: ;
    endcase
  endtask

  task automatic push_tr(logic [31:0] a, logic [31:0] d, logic w, int j);
    tr_t t; t.adr = a; t.dat = d; t.we = w; t.job = j[IW-1:0]; exp_q.push_back(t);
  endtask

  task automatic start(int n);
    exp_q.delete(); s_job = 0; s_rc = 0;
    for (int j = 0; j < n; j++) begin
      push_tr(BASE | 32'h0000_0000, {8'h0, m_addr[j]}, 1'b1, j);
      push_tr(BASE | 32'h0001_0000, {30'h0, m_mem[j]}, 1'b1, j);
      push_tr(BASE | 32'h0002_0000, {14'h0, m_size[j]}, 1'b1, j);
      push_tr(BASE | 32'h0003_0000, 32'd1, 1'b1, j);
      for (int p = 0; p < polls[j]; p++) push_tr(BASE | 32'h0004_0000, 32'h0, 1'b0, j);
    end
    @(negedge clk); go = 1'b1; num_jobs = n[IW:0];
    @(negedge clk); go = 1'b0;
  endtask

  task automatic wait_idle(string nm, int budget);
    int i;
    for (i = 0; i < budget; i++) begin @(negedge clk); if (!busy) break; end
    if (i == budget) begin total++; bad++; $display("FAIL %s_timeout busy=%0b", nm, busy); end
  endtask

  task automatic clr_counts(); done_cnt = 0; tr_cnt = 0; wr_cnt = 0; endtask

  initial begin
    int n, exp_tr, k;
    for (int i = 0; i < N_DESC; i++) begin m_addr[i] = '0; m_mem[i] = '0; m_size[i] = '0; polls[i] = 1; end
    repeat (3) @(negedge clk);
    chk("rst_busy", {31'h0, busy}, 0); chk("rst_done", {31'h0, done}, 0);
    chk("rst_err", {31'h0, err}, 0);   chk("rst_cyc", {31'h0, wb_cyc}, 0);
    chk("rst_adr", wb_adr, 0);         chk("rst_dat", wb_dat, 0);
    chk("rst_we", {31'h0, wb_we}, 0);  chk("rst_job", {30'h0, job_idx}, 0);
    rst_n = 1'b1;

    // single job, valid on the fourth poll; upper cfg bits must be dropped
    cfg(0, 0, 32'hAB01_2345); cfg(0, 1, 32'hFFFF_FFF1); cfg(0, 2, 32'h0000_0008);
    polls[0] = 4; ack_dly_fixed = 0; clr_counts();
    start(1);
    chk("model_len", exp_q.size(), 8);
    chk("model_adr0", exp_q[0].adr, 32'h4000_0000); chk("model_dat0", exp_q[0].dat, 32'h0001_2345);
    chk("model_dat1", exp_q[1].dat, 32'h1);          chk("model_dat2", exp_q[2].dat, 32'h8);
    chk("model_adr3", exp_q[3].adr, 32'h4003_0000);
    wait_idle("one_job", 2000);
    chk("one_done", done_cnt, 1); chk("one_tr", tr_cnt, 8); chk("one_wr", wr_cnt, 4);
    chk("one_err", {31'h0, err}, 0); chk("one_left", exp_q.size(), 0);

    // three jobs, random ack latency
    for (int j = 0; j < 3; j++) begin
      cfg(j, 0, $urandom); cfg(j, 1, $urandom); cfg(j, 2, $urandom);
      polls[j] = $urandom_range(1, 3);
    end
    ack_dly_fixed = -1; clr_counts();
    start(3); wait_idle("three_jobs", 4000);
    chk("three_wr", wr_cnt, 12); chk("three_done", done_cnt, 1); chk("three_left", exp_q.size(), 0);

    // long ack latency, stability checked by monitor
    ack_dly_fixed = 5; clr_counts();
    start(2); wait_idle("slow_ack", 4000);
    chk("slow_done", done_cnt, 1); chk("slow_wr", wr_cnt, 8); chk("slow_left", exp_q.size(), 0);

    // abort while SIZE write awaits its ack
    clr_counts(); start(1);
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (wb_cyc && wb_adr == (BASE | 32'h0002_0000)) break;
    end
    if (k == 200) begin total++; bad++; $display("FAIL abort_no_size_wr k=%0d", k); end
    abort = 1'b1;
    while (exp_q.size() > 1) void'(exp_q.pop_back());
    @(negedge clk); abort = 1'b0;
    wait_idle("abort", 500); repeat (3) @(negedge clk);
    chk("abort_err", {31'h0, err}, 1); chk("abort_busy", {31'h0, busy}, 0);
    chk("abort_done", done_cnt, 0);    chk("abort_wr", wr_cnt, 3);
    chk("abort_left", exp_q.size(), 0);

    // zero jobs: no traffic, done pulse, clears err
    ack_dly_fixed = -1; clr_counts(); start(0);
    chk("zero_err_clr", {31'h0, err}, 0);
    repeat (4) @(negedge clk);
    chk("zero_done", done_cnt, 1); chk("zero_tr", tr_cnt, 0); chk("zero_busy", {31'h0, busy}, 0);

    // random job lists
    for (int it = 0; it < 5; it++) begin
      n = $urandom_range(1, N_DESC);
      for (int j = 0; j < N_DESC; j++) begin
        cfg(j, 0, $urandom); cfg(j, 1, $urandom); cfg(j, 2, $urandom);
        polls[j] = $urandom_range(1, 3);
      end
      clr_counts(); start(n); exp_tr = exp_q.size();
      wait_idle("rand", 8000);
      chk("rand_done", done_cnt, 1); chk("rand_tr", tr_cnt, exp_tr);
      chk("rand_wr", wr_cnt, 4 * n); chk("rand_err", {31'h0, err}, 0);
    end

    // reset mid-run drops cyc at once and clears descriptors
    clr_counts(); start(2);
    for (k = 0; k < 100; k++) begin @(negedge clk); if (wb_cyc) break; end
    rst_n = 1'b0; #1;
    chk("mid_rst_cyc", {31'h0, wb_cyc}, 0); chk("mid_rst_busy", {31'h0, busy}, 0);
    exp_q.delete();
    for (int i = 0; i < N_DESC; i++) begin m_addr[i] = '0; m_mem[i] = '0; m_size[i] = '0; end
    repeat (2) @(negedge clk); rst_n = 1'b1;
    polls[0] = 1; clr_counts(); start(1); wait_idle("post_rst", 2000);
    chk("post_rst_done", done_cnt, 1); chk("post_rst_tr", tr_cnt, 5);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
